rvx10_mc_controller: RTL and testbench
======================================

// Module: rvx10_mc_controller
// PURPOSE
//  Multicycle control FSM for the RVX10 core (RV32I subset plus custom opcode 0001011).
//  Sequences a shared-ALU, single-memory datapath: instruction/data register, A/B/ALUOut/Data registers.
//  Decodes op/funct3/funct7 into per-state datapath enables and ALUControl.
//  Adds a memory-ready handshake, a sticky illegal-instruction halt and a retired-instruction counter.
// PARAMETERS
//  CNT_W  32  width of instret counter
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-high
//  op            in   7      Instr[6:0] from instruction register
//  funct3        in   3      Instr[14:12]
//  funct7        in   7      Instr[31:25]
//  Zero          in   1      ALU zero flag
//  mem_ready     in   1      memory completes access this cycle
//  PCWrite       out  1      load PC from Result
//  AdrSrc        out  1      memory address: 0=PC, 1=Result
//  MemWrite      out  1      memory write strobe
//  IRWrite       out  1      load IR and OldPC
//  ResultSrc     out  2      00=ALUOut 01=Data 10=ALUResult
//  ALUSrcA       out  2      00=PC 01=OldPC 10=A
//  ALUSrcB       out  2      00=B 01=ImmExt 10=const 4
//  ImmSrc        out  2      00=I 01=S 10=B 11=J, decoded from op in every state
//  ALUControl    out  4      ALU operation code
//  RegWrite      out  1      register file write
//  halted        out  1      sticky illegal-instruction flag
//  instr_retired out  1      one-cycle pulse when an instruction completes
//  instret       out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async): state=FETCH, halted=0, instret=0. All write enables (PCWrite, MemWrite, IRWrite, RegWrite) are 0 while reset=1.
//  Outputs are Moore functions of state. Exceptions: PCWrite in BEQ, handshake gating, ALUControl.
//  States and outputs (unlisted outputs are 0 / don't-care muxes):
//   FETCH: AdrSrc=0, A=00, B=10, add, ResultSrc=10. IRWrite and PCWrite only when mem_ready. mem_ready -> DECODE, else hold.
//   DECODE: A=01, B=01, add (branch target into ALUOut). Next state:
//    lw 0000011 / sw 0100011 -> MEMADR; R 0110011 -> EXECR; I 0010011 -> EXECI;
//    beq 1100011 -> BEQ; jal 1101111 -> JAL; 0001011 with legal funct -> EXECX; anything else -> HALT.
//   MEMADR: A=10, B=01, add. lw -> MEMREAD, sw -> MEMWRITE.
//   MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then -> MEMWB.
//   MEMWB: ResultSrc=01, RegWrite=1, retire -> FETCH.
//   MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=mem_ready. mem_ready -> FETCH with retire.
//   EXECR: A=10, B=00, ALUOp=10. EXECI: A=10, B=01, ALUOp=10. EXECX: A=10, B=00, ALUOp=11. Each -> ALUWB.
//   ALUWB: ResultSrc=00, RegWrite=1, retire -> FETCH.
//   JAL: A=01, B=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (writes OldPC+4 to rd).
//   BEQ: A=10, B=00, sub, ResultSrc=00, PCWrite=Zero, retire -> FETCH.
//   HALT: all enables 0, halted=1. Stays in HALT until reset.
//  ALUControl encoding:
//   ALUOp=00 add 0000; ALUOp=01 sub 0001.
//   ALUOp=10 by funct3: 000 add 0000, or sub 0001 when funct7[5]&op[5]; 010 slt 0101; 110 or 0011; 111 and 0010.
//   ALUOp=11 by {funct7,funct3}:
//    0000000: 000 ANDN 1000, 001 ORN 1001, 010 XNOR 1010
//    0000001: 000 MIN 1011, 001 MAX 1100, 010 MINU 1101, 011 MAXU 1110
//    0000010: 000 ROL 1111, 001 ROR 0110
//    0000011: 000 ABS 0111
//   Any other {funct7,funct3} under 0001011 is illegal: DECODE -> HALT.
//  Retire: instr_retired=1 for exactly one cycle, and instret+=1 on the same edge.
//  Reset asserted mid-instruction (including mid-wait) aborts the instruction immediately and must not produce a write strobe.
// TESTING
//  add x3,x1,x2, mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB. RegWrite only in cycle 4. instret 0->1.
//  lw with mem_ready low 3 cycles in MEMREAD -> FSM holds; MEMWB follows the first ready cycle; total 5+3 cycles.
//  sw with mem_ready=0 then 1 -> MemWrite asserted exactly one cycle (the ready cycle).
//  beq with Zero=1 -> PCWrite=1 in BEQ. Zero=0 -> PCWrite=0. Both retire in 3 cycles.
//  Custom funct7=0000001 funct3=011 -> ALUControl=1110 in EXECX.
//  Custom funct7=0000100 -> HALT, halted=1 sticky, no enables.
//  Reset pulse during MEMREAD -> state FETCH, counters 0, no RegWrite.
//  Preload instret=2^CNT_W-1 (force) and retire -> wraps to 0.

Source files
------------

// File: rtl/rvx10_mc_controller.sv
// Multicycle control FSM for the RVX10 core (RV32I subset + custom 0001011 ops).
// Latency: 3-5 states per instruction plus memory wait cycles; outputs are Moore of state.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; HALT holds until reset.
module rvx10_mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [3:0]       ALUControl,
  output logic             RegWrite,
  output logic             halted,
  output logic             instr_retired,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_X   = 7'b0001011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_EXECX, S_ALUWB, S_JAL, S_BEQ, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       alu_op;
  logic             retire;
  logic             x_legal;

  // Custom-opcode legality: only the listed {funct7,funct3} pairs exist.
  always_comb begin
    x_legal = 1'b0;
    case ({funct7, funct3})
      10'b0000000_000, 10'b0000000_001, 10'b0000000_010,
      10'b0000001_000, 10'b0000001_001, 10'b0000001_010, 10'b0000001_011,
      10'b0000010_000, 10'b0000010_001,
      10'b0000011_000: x_legal = 1'b1;
      default:         x_legal = 1'b0;
    endcase
  end

  // Next-state and per-state datapath controls; write strobes are killed while reset is high.
  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target OldPC+imm is parked in ALUOut here.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_X:         state_d = x_legal ? S_EXECX : S_HALT;
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        if (mem_ready) begin
          MemWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECX: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b11;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        PCWrite = Zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
    end
    instr_retired = retire;
    halted_d      = halted_q | (state_d == S_HALT);
    instret_d     = instret_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // ALU operation from ALUOp and the instruction function fields.
  always_comb begin
    ALUControl = 4'b0000;
    case (alu_op)
      2'b00: ALUControl = 4'b0000;
      2'b01: ALUControl = 4'b0001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (funct7[5] & op[5]) ? 4'b0001 : 4'b0000;
          3'b010:  ALUControl = 4'b0101;
          3'b110:  ALUControl = 4'b0011;
          3'b111:  ALUControl = 4'b0010;
          default: ALUControl = 4'b0000;
        endcase
      end
      default: begin
        case ({funct7, funct3})
          10'b0000000_000: ALUControl = 4'b1000;
          10'b0000000_001: ALUControl = 4'b1001;
          10'b0000000_010: ALUControl = 4'b1010;
          10'b0000001_000: ALUControl = 4'b1011;
          10'b0000001_001: ALUControl = 4'b1100;
          10'b0000001_010: ALUControl = 4'b1101;
          10'b0000001_011: ALUControl = 4'b1110;
          10'b0000010_000: ALUControl = 4'b1111;
          10'b0000010_001: ALUControl = 4'b0110;
          10'b0000011_000: ALUControl = 4'b0111;
          default:         ALUControl = 4'b0000;
        endcase
      end
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // State, sticky halt and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      halted_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      instret_q <= instret_d;
    end
  end

  assign halted  = halted_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_rvx10_mc_controller.sv
// Directed bench for the RVX10 multicycle controller.
// Each cycle compares the full control vector and the instret counter against hand-computed values.
// mem_ready is driven by the bench to exercise the memory wait states.
module tb_rvx10_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  op = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halted, instr_retired;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [3:0]  ALUControl;
  logic [31:0] instret;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [1:0]  imm_exp = 2'b00;

  rvx10_mc_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .halted(halted),
    .instr_retired(instr_retired), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Packs {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,retired,halted}.
  function automatic logic [18:0] ev(input int pcw, input int adr, input int mw, input int irw,
                                     input int rw, input int rs, input int sa, input int sb,
                                     input int alu, input int ret, input int hlt);
    return {1'(pcw), 1'(adr), 1'(mw), 1'(irw), 1'(rw), 2'(rs), 2'(sa), 2'(sb),
            imm_exp, 4'(alu), 1'(ret), 1'(hlt)};
  endfunction

  task automatic setins(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [1:0] imm);
    op = o; funct3 = f3; funct7 = f7; imm_exp = imm;
  endtask

  // Called just after a rising edge; checks the current cycle, then advances one cycle.
  task automatic step(input string tag, input logic [18:0] exp);
    logic [18:0] obs;
    #1;
    obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, instr_retired, halted};
    check({tag, " ctl"}, {13'd0, obs}, {13'd0, exp});
    check({tag, " cnt"}, instret, exp_cnt);
    @(posedge clk);
    #1;
    if (exp[1]) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    #1 reset = 1'b1;
    mem_ready = 1'b1;
    setins(7'b0110011, 3'b000, 7'b0000000, 2'b00);
    // Reset held across an edge with mem_ready high: FETCH muxes, no strobes.
    step("rst0", ev(0,0,0,0,0,2,0,2,0,0,0));
    step("rst1", ev(0,0,0,0,0,2,0,2,0,0,0));
    reset = 1'b0;

    // add x3,x1,x2
    step("add F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("add D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("add X", ev(0,0,0,0,0,0,2,0,0,0,0));
    step("add W", ev(0,0,0,0,1,0,0,0,0,1,0));

    // sub and slt on R-type, addi with funct7[5] set must stay add
    setins(7'b0110011, 3'b000, 7'b0100000, 2'b00);
    step("sub F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("sub D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("sub X", ev(0,0,0,0,0,0,2,0,1,0,0));
    step("sub W", ev(0,0,0,0,1,0,0,0,0,1,0));
    setins(7'b0110011, 3'b010, 7'b0000000, 2'b00);
    step("slt F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("slt D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("slt X", ev(0,0,0,0,0,0,2,0,5,0,0));
    step("slt W", ev(0,0,0,0,1,0,0,0,0,1,0));
    setins(7'b0010011, 3'b000, 7'b0100000, 2'b00);
    step("addi F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("addi D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("addi X", ev(0,0,0,0,0,0,2,1,0,0,0));
    step("addi W", ev(0,0,0,0,1,0,0,0,0,1,0));

    // lw with three not-ready cycles in MEMREAD: 8 cycles total
    setins(7'b0000011, 3'b010, 7'b0000000, 2'b00);
    step("lw F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("lw D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("lw A", ev(0,0,0,0,0,0,2,1,0,0,0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw Rwait", ev(0,1,0,0,0,0,0,0,0,0,0));
    mem_ready = 1'b1;
    step("lw Rrdy", ev(0,1,0,0,0,0,0,0,0,0,0));
    step("lw WB", ev(0,0,0,0,1,1,0,0,0,1,0));

    // sw: MemWrite only in the ready cycle
    setins(7'b0100011, 3'b010, 7'b0000000, 2'b01);
    step("sw F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("sw D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("sw A", ev(0,0,0,0,0,0,2,1,0,0,0));
    mem_ready = 1'b0;
    step("sw Wwait", ev(0,1,0,0,0,0,0,0,0,0,0));
    mem_ready = 1'b1;
    step("sw Wrdy", ev(0,1,1,0,0,0,0,0,0,1,0));

    // beq taken / not taken
    setins(7'b1100011, 3'b000, 7'b0000000, 2'b10);
    Zero = 1'b1;
    step("beq1 F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("beq1 D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("beq1 B", ev(1,0,0,0,0,0,2,0,1,1,0));
    Zero = 1'b0;
    step("beq0 F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("beq0 D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("beq0 B", ev(0,0,0,0,0,0,2,0,1,1,0));

    // jal
    setins(7'b1101111, 3'b000, 7'b0000000, 2'b11);
    step("jal F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("jal D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("jal J", ev(1,0,0,0,0,0,1,2,0,0,0));
    step("jal W", ev(0,0,0,0,1,0,0,0,0,1,0));

    // custom MAXU and ROR
    setins(7'b0001011, 3'b011, 7'b0000001, 2'b00);
    step("maxu F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("maxu D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("maxu X", ev(0,0,0,0,0,0,2,0,14,0,0));
    step("maxu W", ev(0,0,0,0,1,0,0,0,0,1,0));
    setins(7'b0001011, 3'b001, 7'b0000010, 2'b00);
    step("ror F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("ror D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("ror X", ev(0,0,0,0,0,0,2,0,6,0,0));

    // Counter wrap: preload all-ones just before the ALUWB retire edge
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    exp_cnt = 32'hFFFF_FFFF;
    step("wrap W", ev(0,0,0,0,1,0,0,0,0,1,0));
    check("wrap zero", instret, 32'd0);

    // Reset pulse while lw waits in MEMREAD
    setins(7'b0000011, 3'b010, 7'b0000000, 2'b00);
    step("lwr F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("lwr D", ev(0,0,0,0,0,0,1,1,0,0,0));
    step("lwr A", ev(0,0,0,0,0,0,2,1,0,0,0));
    mem_ready = 1'b0;
    step("lwr Rwait", ev(0,1,0,0,0,0,0,0,0,0,0));
    mem_ready = 1'b1;
    reset = 1'b1;
    exp_cnt = 32'd0;
    step("midrst", ev(0,0,0,0,0,2,0,2,0,0,0));
    reset = 1'b0;

    // Illegal custom funct7: HALT is sticky and inert
    setins(7'b0001011, 3'b000, 7'b0000100, 2'b00);
    step("ill F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("ill D", ev(0,0,0,0,0,0,1,1,0,0,0));
    setins(7'b0110011, 3'b000, 7'b0000000, 2'b00);
    for (int i = 0; i < 3; i++) step("halt", ev(0,0,0,0,0,0,0,0,0,0,1));
    reset = 1'b1;
    step("halt rst", ev(0,0,0,0,0,2,0,2,0,0,0));
    reset = 1'b0;
    step("post F", ev(1,0,0,1,0,2,0,2,0,0,0));
    step("post D", ev(0,0,0,0,0,0,1,1,0,0,0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
